// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and constants for the two-port wishbone arbiter
package wb_arb_pkg;

  // Bus ownership state of the arbiter
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } arb_state_e;

  // Requester port indices, also the encoding of the round-robin "last" flag
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Transfer width encodings carried on *_width / o_data_width
  localparam logic [1:0] WIDTH_BYTE  = 2'b01;
  localparam logic [1:0] WIDTH_SHORT = 2'b10;
  localparam logic [1:0] WIDTH_WORD  = 2'b11;

  // Round-robin partner of a port
  function automatic logic other_port(input logic port);
    return ~port;
  endfunction

  // Owned-state encoding for a given port index
  function automatic arb_state_e own_state(input logic port);
    return (port == PORT_I) ? OWN_I : OWN_D;
  endfunction

endpackage

// File: rtl/wb_watchdog.sv
// rtl/wb_watchdog.sv - no-ack watchdog producing a one-cycle expiry pulse
module wb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);

  // Counter holds the number of completed waiting cycles, so it tops out at TIMEOUT-1
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The current waiting cycle is the TIMEOUT-th one when the count already holds TIMEOUT-1
  always_comb begin
    o_expired = i_run & ~i_clear & (cnt_q == CW'(TIMEOUT - 1));
  end

  // Count consecutive waiting cycles; any break in waiting or an expiry restarts from zero
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear || !i_run || o_expired) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// rtl/wb_bus_arbiter.sv - shares one pipelined wishbone master between fetch and data ports
import wb_arb_pkg::*;

module wb_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MAX_OUT = 4,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  // instruction port
  input  logic          i_ib_cyc,
  input  logic          i_ib_stb,
  input  logic          i_ib_we,
  input  logic [AW-1:0] i_ib_addr,
  input  logic [DW-1:0] i_ib_data,
  input  logic [1:0]    i_ib_width,
  output logic [DW-1:0] o_ib_data,
  output logic          o_ib_ack,
  output logic          o_ib_stall,
  output logic          o_ib_err,
  // data port
  input  logic          i_db_cyc,
  input  logic          i_db_stb,
  input  logic          i_db_we,
  input  logic [AW-1:0] i_db_addr,
  input  logic [DW-1:0] i_db_data,
  input  logic [1:0]    i_db_width,
  output logic [DW-1:0] o_db_data,
  output logic          o_db_ack,
  output logic          o_db_stall,
  output logic          o_db_err,
  // shared master
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [DW-1:0] o_wb_data,
  output logic [1:0]    o_data_width,
  input  logic [DW-1:0] i_wb_data,
  input  logic          i_wb_ack,
  input  logic          i_wb_stall
);

  localparam int OW = $clog2(MAX_OUT + 1);

  arb_state_e    state_q;
  arb_state_e    state_d;
  logic          last_q;
  logic          last_d;
  logic [OW-1:0] out_q;
  logic [OW-1:0] out_d;

  // Selected owner request (all zero while idle)
  logic          own_cyc;
  logic          own_stb;
  logic          own_we;
  logic [AW-1:0] own_addr;
  logic [DW-1:0] own_data;
  logic [1:0]    own_width;

  logic owning;
  logic ack_valid;
  logic full;
  logic release_req;
  logic abort;
  logic mst_stb;
  logic accept;
  logic wd_run;
  logic wd_clear;

  // Request mux keyed only on the registered state so master outputs never glitch on arbitration
  always_comb begin
    own_cyc   = 1'b0;
    own_stb   = 1'b0;
    own_we    = 1'b0;
    own_addr  = '0;
    own_data  = '0;
    own_width = '0;
    case (state_q)
      OWN_I: begin
        own_cyc   = i_ib_cyc;
        own_stb   = i_ib_stb;
        own_we    = i_ib_we;
        own_addr  = i_ib_addr;
        own_data  = i_ib_data;
        own_width = i_ib_width;
      end
      OWN_D: begin
        own_cyc   = i_db_cyc;
        own_stb   = i_db_stb;
        own_we    = i_db_we;
        own_addr  = i_db_addr;
        own_data  = i_db_data;
        own_width = i_db_width;
      end
      default: begin
        own_cyc = 1'b0;
      end
    endcase
  end

  // Handshake qualifiers: acks with nothing outstanding are dropped, and an ack
  // frees its slot in the same cycle so a full pipe can take a new strobe at once
  always_comb begin
    owning      = (state_q != IDLE);
    ack_valid   = owning & i_wb_ack & (out_q != '0);
    full        = (out_q == OW'(MAX_OUT)) & ~ack_valid;
    release_req = owning & ~own_cyc;
    mst_stb     = owning & own_cyc & own_stb & ~full & ~abort;
    accept      = mst_stb & ~i_wb_stall;
    wd_run      = owning & (out_q != '0) & ~ack_valid;
    wd_clear    = ~owning | release_req;
  end

  wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (wd_clear),
    .i_run     (wd_run),
    .o_expired (abort)
  );

  // State, round-robin and outstanding-count registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= PORT_D;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      out_q   <= out_d;
    end
  end

  // Next-state: grant from idle with round-robin on a tie, drop back on release or abort
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (i_ib_cyc && i_db_cyc) begin
          last_d  = other_port(last_q);
          state_d = own_state(other_port(last_q));
        end else if (i_ib_cyc) begin
          last_d  = PORT_I;
          state_d = OWN_I;
        end else if (i_db_cyc) begin
          last_d  = PORT_D;
          state_d = OWN_D;
        end
      end
      OWN_I, OWN_D: begin
        if (release_req || abort) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outstanding count; discarded whenever the bus is not held across the edge
  always_comb begin
    out_d = out_q;
    if (state_q == IDLE || state_d == IDLE) begin
      out_d = '0;
    end else if (accept && !ack_valid) begin
      out_d = out_q + OW'(1);
    end else if (!accept && ack_valid) begin
      out_d = out_q - OW'(1);
    end
  end

  // Outputs: owner sees the slave combinationally; the waiting port is stalled and silent
  always_comb begin
    o_wb_cyc     = owning & own_cyc & ~abort;
    o_wb_stb     = mst_stb;
    o_wb_we      = own_we;
    o_wb_addr    = own_addr;
    o_wb_data    = own_data;
    o_data_width = own_width;

    o_ib_data  = '0;
    o_ib_ack   = 1'b0;
    o_ib_stall = 1'b1;
    o_ib_err   = 1'b0;
    o_db_data  = '0;
    o_db_ack   = 1'b0;
    o_db_stall = 1'b1;
    o_db_err   = 1'b0;

    // The abort cycle also stalls the owner so no strobe is believed accepted
    if (state_q == OWN_I) begin
      o_ib_data  = i_wb_data;
      o_ib_ack   = ack_valid;
      o_ib_stall = i_wb_stall | full | abort;
      o_ib_err   = abort;
    end else if (state_q == OWN_D) begin
      o_db_data  = i_wb_data;
      o_db_ack   = ack_valid;
      o_db_stall = i_wb_stall | full | abort;
      o_db_err   = abort;
    end
  end

endmodule

// File: doc/wb_bus_arbiter.md
# wb_bus_arbiter

Two-port Wishbone (pipelined) arbiter that shares the single CPU bus master port (`o_wb_*`/`i_wb_*`) between the instruction-fetch requester and the load/store/push/pop data requester. Grants one owner at a time, locks the bus for that owner's whole `cyc` cycle, and tracks outstanding transfers. Aborts a stuck transfer with an error after a programmable timeout. Sits inside `cpu` between the fetch-phase and memory-phase `fetch` instances and the external bus.

## Interface

Parameters:
- `AW`, 32, address width
- `DW`, 32, data width
- `MAX_OUT`, 4, maximum outstanding (accepted, un-acked) strobes; power of two, ≥1
- `TIMEOUT`, 255, cycles without ack while outstanding > 0 before abort; ≥2

Ports:
- `clk`  in  1  single clock, all logic on posedge
- `reset`  in  1  synchronous, active-high
- `i_ib_cyc`, `i_ib_stb`, `i_ib_we`  in  1 each  instruction-port requester controls
- `i_ib_addr`  in  AW  instruction-port address
- `i_ib_data`  in  DW  instruction-port write data
- `i_ib_width`  in  2  instruction-port data width
- `o_ib_data`  out  DW  read data to instruction port
- `o_ib_ack`, `o_ib_stall`, `o_ib_err`  out  1 each  instruction-port responses
- `i_db_*` / `o_db_*`  same set for the data port
- `o_wb_cyc`, `o_wb_stb`, `o_wb_we`  out  1 each  master controls
- `o_wb_addr`  out  AW  master address
- `o_wb_data`  out  DW  master write data
- `o_data_width`  out  2  master data width
- `i_wb_data`  in  DW  master read data
- `i_wb_ack`, `i_wb_stall`  in  1 each  master responses

## Operation

- States: `IDLE`, `OWN_I`, `OWN_D`; register `last` (port last served, reset = D).
- `IDLE`: all master outputs 0; both stalls 1; acks and errs 0.
  - Only I cyc → `OWN_I`. Only D cyc → `OWN_D`.
  - Both → the port ≠ `last` (round-robin). Set `last` on grant.
- `OWN_x`:
  - Master `cyc/we/addr/data/width` = port x inputs; `o_wb_stb` = `i_x_stb & ~full`.
  - `o_x_stall` = `i_wb_stall | full`; `o_x_ack` = `i_wb_ack`; `o_x_data` = `i_wb_data`.
  - The other port sees stall=1, ack=0, err=0, data=0.
- Outstanding counter `out` (0..MAX_OUT):
  - +1 on `o_wb_stb & ~i_wb_stall`; −1 on `i_wb_ack`; both in the same cycle → unchanged.
  - `full` = (`out == MAX_OUT`).
  - Ack with `out == 0` is ignored: not forwarded, no underflow.
- Release: owner deasserts cyc → `IDLE` next cycle; `out` and timer cleared (abort semantics); later acks are ignored.
- Watchdog:
  - Counts while `out > 0` and no ack. Cleared on ack, on `out == 0`, and on leaving `OWN_x`.
  - Reaching TIMEOUT: `o_x_err` = 1 for exactly one cycle, `o_wb_cyc` and `o_wb_stb` forced 0 that cycle, then `IDLE`, `out` cleared.
- `reset` (any state, mid-transfer included): `IDLE`, `out` = 0, timer = 0, `last` = D. All outputs take their `IDLE` values the next cycle.

## Timing

- Grant latency: requester cyc rises at cycle N → `o_wb_cyc` is 1 from cycle N+1; requester stall is 1 during N.
- Response path is combinational: ack, data and stall pass through with 0 cycles latency.
- Ownership handover costs exactly one `IDLE` cycle between owners.
- Error pulse is 1 cycle wide, asserted at timer == TIMEOUT, so TIMEOUT cycles after the last ack or acceptance.
- Master outputs are a combinational mux selected by the registered state only, so there is no cyc glitch on arbitration.

## Structure

- Package `wb_arb_pkg`:
  - state enum (`IDLE`, `OWN_I`, `OWN_D`)
  - port index constants `PORT_I` = 0, `PORT_D` = 1
  - width encodings (byte, short, word = `2'b11`)
- Sub-module `wb_watchdog`, parameterised by TIMEOUT:
  - inputs `clk`, `reset`, `i_clear`, `i_run`
  - output `o_expired`, a one-cycle pulse
- Arbiter FSM, outstanding counter and muxes live in the top module.

## Test plan

- Single fetch: I cyc+stb, addr 0xb0000000, slave acks 2 cycles later with data 0x11223344 → `o_wb_cyc` at N+1, `o_ib_ack` with that data, `o_db_stall` = 1 throughout.
- Simultaneous request after reset: I and D assert cyc together → I granted first. After I drops cyc, one `IDLE` cycle, then D granted. Store addr 0xb000fffc, data 0xdeadbeef appears on the master with `o_wb_we` = 1.
- Pipelining limit: D issues 5 strobes, slave never stalls and withholds acks, MAX_OUT=4 → 4 accepted, 5th sees `o_db_stall` = 1 and master `stb` = 0. One ack → 5th accepted the same cycle.
- Timeout: I strobe accepted, no ack, TIMEOUT=8 → `o_ib_err` = 1 for one cycle 8 cycles after acceptance, `o_wb_cyc` = 0 that cycle, `IDLE` next. A late ack is not forwarded.
- Reset mid-transfer: `reset` asserted while `OWN_D` with `out` = 2 → next cycle all master outputs 0, both stalls 1. After release, I+D tie grants I.
